// File: rtl/apb_master_bridge_mp_if.sv
// APB bus bundle between the bridge and its slaves.
// PRDATA, PREADY and PSLVERR_IN carry one lane per slave.
interface apb_master_bridge_mp_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLAVES = 2
);
    logic [ADDR_WIDTH-1:0]            PADDR;
    logic [NUM_SLAVES-1:0]            PSEL;
    logic                             PENABLE;
    logic                             PWRITE;
    logic [DATA_WIDTH-1:0]            PWDATA;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]            PREADY;
    logic [NUM_SLAVES-1:0]            PSLVERR_IN;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR_IN
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR_IN
    );
endinterface

// File: rtl/apb_master_bridge_mp.sv
// APB master bridge: user request port to an APB bus with NUM_SLAVES one-hot selects,
// wait states, bounded-wait timeout, decode-error detection and a completion pulse.
//
// state  | meaning
// IDLE   | no transfer in flight, waiting for transfer=1
// SETUP  | APB setup phase, PSEL high, PENABLE low
// ACCESS | APB access phase, waiting for PREADY of the selected slave or timeout
// DERR   | address decoded to a non-existent slave, completes with error next edge
module apb_master_bridge_mp #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLAVES = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   transfer,
    input  logic                   READ_WRITE,
    input  logic [ADDR_WIDTH-1:0]  apb_write_paddr,
    input  logic [DATA_WIDTH-1:0]  apb_write_data,
    input  logic [ADDR_WIDTH-1:0]  apb_read_paddr,
    output logic [DATA_WIDTH-1:0]  apb_read_data_out,
    output logic                   PSLVERR,
    output logic                   xfer_done,
    output logic                   busy,
    apb_master_bridge_mp_if.master apb
);
    localparam int SEL_BITS = (NUM_SLAVES > 2) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_BITS = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DERR   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [SEL_BITS-1:0]   idx_q;
    logic [NUM_SLAVES-1:0] psel_q;
    logic                  penable_q;
    logic [CNT_BITS-1:0]   wait_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  slverr_q;
    logic                  done_q;
    logic                  busy_q;

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [SEL_BITS-1:0]   req_idx;
    logic                  req_valid;
    logic                  take_req;
    logic                  complete;
    logic                  cpl_err;
    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic [SEL_BITS-1:0]   idx_d;
    logic [NUM_SLAVES-1:0] psel_d;
    logic [CNT_BITS-1:0]   wait_d;

    assign req_addr  = READ_WRITE ? apb_read_paddr : apb_write_paddr;
    assign req_idx   = req_addr[ADDR_WIDTH-1 -: SEL_BITS];
    assign req_valid = (32'(req_idx) < NUM_SLAVES);

    // Only the latched slave's lanes are observed; other slaves may drive anything.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == SEL_BITS'(i)) begin
                sel_ready = apb.PREADY[i];
                sel_err   = apb.PSLVERR_IN[i];
                sel_rdata = apb.PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        cpl_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d = req_valid ? SETUP : DERR;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    complete = 1'b1;
                    cpl_err  = sel_err;
                end else if ((TIMEOUT != 0) && (wait_q == '0)) begin
                    complete = 1'b1;
                    cpl_err  = 1'b1;
                end
            end
            DERR: begin
                complete = 1'b1;
                cpl_err  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A request present on the completing edge chains straight into the next transfer.
        if (complete) begin
            state_d = transfer ? (req_valid ? SETUP : DERR) : IDLE;
        end
    end

    assign take_req = transfer && ((state_q == IDLE) || complete);

    // Wait timer counts down from TIMEOUT; reaching zero while still not ready is the timeout.
    always_comb begin
        wait_d = wait_q;
        if (take_req) begin
            wait_d = CNT_BITS'(TIMEOUT);
        end else if (complete) begin
            wait_d = '0;
        end else if ((state_q == ACCESS) && (wait_q != '0)) begin
            wait_d = wait_q - CNT_BITS'(1);
        end
    end

    assign idx_d = take_req ? req_idx : idx_q;

    always_comb begin
        psel_d = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            psel_d[i] = ((state_d == SETUP) || (state_d == ACCESS)) && (idx_d == SEL_BITS'(i));
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            idx_q     <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            wait_q    <= '0;
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            psel_q    <= psel_d;
            penable_q <= (state_d == ACCESS);
            busy_q    <= (state_d != IDLE);
            done_q    <= complete;
            wait_q    <= wait_d;
            if (take_req) begin
                write_q <= ~READ_WRITE;
                addr_q  <= req_addr;
                wdata_q <= apb_write_data;
                idx_q   <= req_idx;
            end
            if (complete) begin
                slverr_q <= cpl_err;
                if (!write_q) begin
                    rdata_q <= cpl_err ? '0 : sel_rdata;
                end
            end
        end
    end

    assign apb.PADDR         = addr_q;
    assign apb.PSEL          = psel_q;
    assign apb.PENABLE       = penable_q;
    assign apb.PWRITE        = write_q;
    assign apb.PWDATA        = wdata_q;
    assign apb_read_data_out = rdata_q;
    assign PSLVERR           = slverr_q;
    assign xfer_done         = done_q;
    assign busy              = busy_q;
endmodule

// File: tb/tb_apb_master_bridge_mp.sv
// Self-checking bench for apb_master_bridge_mp: three slaves, TIMEOUT=4, scoreboard of
// expected completion status checked on every xfer_done pulse.
module tb_apb_master_bridge_mp;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int NS = 3;
    localparam int TO = 4;

    logic          PCLK            = 1'b0;
    logic          PRESETn         = 1'b0;
    logic          transfer        = 1'b0;
    logic          READ_WRITE      = 1'b0;
    logic [AW-1:0] apb_write_paddr = '0;
    logic [AW-1:0] apb_read_paddr  = '0;
    logic [DW-1:0] apb_write_data  = '0;
    logic [DW-1:0] apb_read_data_out;
    logic          PSLVERR;
    logic          xfer_done;
    logic          busy;

    apb_master_bridge_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) apb ();

    apb_master_bridge_mp #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .TIMEOUT(TO)
    ) dut (
        .PCLK              (PCLK),
        .PRESETn           (PRESETn),
        .transfer          (transfer),
        .READ_WRITE        (READ_WRITE),
        .apb_write_paddr   (apb_write_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_paddr    (apb_read_paddr),
        .apb_read_data_out (apb_read_data_out),
        .PSLVERR           (PSLVERR),
        .xfer_done         (xfer_done),
        .busy              (busy),
        .apb               (apb)
    );

    always #5 PCLK = ~PCLK;

    // Slave model: selected slave is ready after wait_cfg ACCESS cycles (-1 = never);
    // unselected slaves drive ready=1 and error=1 so a wrong lane choice shows up.
    int   wait_cfg = 0;
    logic err_cfg  = 1'b0;
    int   acc_cnt  = 0;

    assign apb.PRDATA = {8'h5A, 8'h3C, 8'hC3};

    always @(posedge PCLK) acc_cnt <= apb.PENABLE ? acc_cnt + 1 : 0;

    always_comb begin
        apb.PREADY     = '0;
        apb.PSLVERR_IN = '0;
        for (int i = 0; i < NS; i++) begin
            apb.PREADY[i]     = apb.PSEL[i] ? ((wait_cfg >= 0) && (acc_cnt >= wait_cfg)) : 1'b1;
            apb.PSLVERR_IN[i] = apb.PSEL[i] ? err_cfg : 1'b1;
        end
    end

    typedef struct packed {
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] model_rdata = '0;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic push_exp(input bit rd, input bit err, input logic [DW-1:0] data);
        exp_t e;
        if (rd) model_rdata = err ? '0 : data;
        e.err   = err;
        e.rdata = model_rdata;
        exp_q.push_back(e);
    endtask

    // The unused address bus carries the inverted address so a wrong address mux is visible.
    task automatic drive_req(input bit rd, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        READ_WRITE = rd;
        if (rd) begin
            apb_read_paddr  = addr;
            apb_write_paddr = ~addr;
        end else begin
            apb_write_paddr = addr;
            apb_read_paddr  = ~addr;
        end
        apb_write_data = data;
        transfer       = 1'b1;
    endtask

    task automatic run_to_done(input logic [NS-1:0] exp_sel, input logic [AW-1:0] exp_addr,
                               input logic exp_write, output int sel_cyc, output int en_cyc,
                               output int unstable, output bit done);
        sel_cyc  = 0;
        en_cyc   = 0;
        unstable = 0;
        done     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (xfer_done === 1'b1) begin
                done = 1'b1;
                break;
            end
            if (apb.PSEL === exp_sel) sel_cyc++;
            else unstable++;
            if (apb.PENABLE === 1'b1) en_cyc++;
            if (apb.PADDR !== exp_addr || apb.PWRITE !== exp_write) unstable++;
            @(negedge PCLK);
        end
    endtask

    always @(negedge PCLK) begin
        if (PRESETn && xfer_done === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: xfer_done=1 at %0t with 0 transfers pending", $time);
            end else begin
                mon_e = exp_q.pop_front();
                n_checks++;
                if (PSLVERR !== mon_e.err || apb_read_data_out !== mon_e.rdata) begin
                    n_fail++;
                    $display("FAIL completion_status: PSLVERR=%b rdata=%h, expected %b %h at %0t",
                             PSLVERR, apb_read_data_out, mon_e.err, mon_e.rdata, $time);
                end
            end
        end
    end

    task automatic test_reset();
        PRESETn = 1'b0;
        repeat (2) @(negedge PCLK);
        n_checks++;
        if ({apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA,
             apb_read_data_out, PSLVERR, xfer_done, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: psel=%b en=%b wr=%b addr=%h wdata=%h rdata=%h err=%b done=%b busy=%b, expected all 0",
                     apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA,
                     apb_read_data_out, PSLVERR, xfer_done, busy);
        end
        PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);
        n_checks++;
        if (busy !== 1'b0 || apb.PSEL !== '0 || xfer_done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b psel=%b done=%b, expected 0 000 0", busy, apb.PSEL, xfer_done);
        end
    endtask

    task automatic test_zero_wait_write();
        wait_cfg = 0;
        err_cfg  = 1'b0;
        drive_req(1'b0, 9'h012, 8'hA5);
        push_exp(1'b0, 1'b0, '0);
        @(negedge PCLK);
        transfer        = 1'b0;
        apb_write_data  = 8'hFF;
        apb_write_paddr = 9'h0FF;
        n_checks++;
        if (apb.PSEL !== 3'b001 || apb.PENABLE !== 1'b0 || apb.PWRITE !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL write_setup: psel=%b en=%b wr=%b busy=%b, expected 001 0 1 1",
                     apb.PSEL, apb.PENABLE, apb.PWRITE, busy);
        end
        n_checks++;
        if (apb.PADDR !== 9'h012 || apb.PWDATA !== 8'hA5) begin
            n_fail++;
            $display("FAIL write_setup_bus: addr=%h wdata=%h, expected 012 a5", apb.PADDR, apb.PWDATA);
        end
        @(negedge PCLK);
        n_checks++;
        if (apb.PENABLE !== 1'b1 || apb.PSEL !== 3'b001 || apb.PADDR !== 9'h012 || apb.PWDATA !== 8'hA5) begin
            n_fail++;
            $display("FAIL write_access: en=%b psel=%b addr=%h wdata=%h, expected 1 001 012 a5",
                     apb.PENABLE, apb.PSEL, apb.PADDR, apb.PWDATA);
        end
        @(negedge PCLK);
        n_checks++;
        if (xfer_done !== 1'b1 || apb.PSEL !== '0 || apb.PENABLE !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL write_complete: done=%b psel=%b en=%b busy=%b, expected 1 000 0 0",
                     xfer_done, apb.PSEL, apb.PENABLE, busy);
        end
        @(negedge PCLK);
        n_checks++;
        if (xfer_done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse_width: done=%b, expected 0", xfer_done);
        end
    endtask

    task automatic test_read_waits();
        int sel_cyc, en_cyc, unstable;
        bit done;
        wait_cfg = 2;
        drive_req(1'b1, 9'h085, 8'h00);
        push_exp(1'b1, 1'b0, 8'h3C);
        @(negedge PCLK);
        transfer       = 1'b0;
        READ_WRITE     = 1'b0;
        apb_read_paddr = 9'h000;
        run_to_done(3'b010, 9'h085, 1'b0, sel_cyc, en_cyc, unstable, done);
        n_checks++;
        if (!done || sel_cyc != 4 || en_cyc != 3 || unstable != 0) begin
            n_fail++;
            $display("FAIL read_waits: done=%b sel_cycles=%0d en_cycles=%0d unstable=%0d, expected 1 4 3 0",
                     done, sel_cyc, en_cyc, unstable);
        end
        @(negedge PCLK);
    endtask

    task automatic test_timeout();
        int sel_cyc, en_cyc, unstable;
        bit done;
        wait_cfg = -1;
        drive_req(1'b1, 9'h105, 8'h00);
        push_exp(1'b1, 1'b1, '0);
        @(negedge PCLK);
        transfer = 1'b0;
        run_to_done(3'b100, 9'h105, 1'b0, sel_cyc, en_cyc, unstable, done);
        n_checks++;
        if (!done || sel_cyc != TO + 2 || en_cyc != TO + 1 || unstable != 0) begin
            n_fail++;
            $display("FAIL timeout_len: done=%b sel_cycles=%0d en_cycles=%0d unstable=%0d, expected 1 %0d %0d 0",
                     done, sel_cyc, en_cyc, unstable, TO + 2, TO + 1);
        end
        n_checks++;
        if (apb.PSEL !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_idle: psel=%b busy=%b, expected 000 0", apb.PSEL, busy);
        end
        wait_cfg = 0;
        @(negedge PCLK);
    endtask

    task automatic test_back_to_back();
        wait_cfg = 0;
        err_cfg  = 1'b0;
        drive_req(1'b0, 9'h010, 8'h5E);
        push_exp(1'b0, 1'b0, '0);
        @(negedge PCLK);
        READ_WRITE     = 1'b1;
        apb_read_paddr = 9'h090;
        n_checks++;
        if (apb.PSEL !== 3'b001 || apb.PENABLE !== 1'b0 || apb.PWRITE !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_setup1: psel=%b en=%b wr=%b, expected 001 0 1", apb.PSEL, apb.PENABLE, apb.PWRITE);
        end
        @(negedge PCLK);
        push_exp(1'b1, 1'b0, 8'h3C);
        n_checks++;
        if (apb.PSEL !== 3'b001 || apb.PENABLE !== 1'b1 || apb.PWRITE !== 1'b1 || apb.PWDATA !== 8'h5E) begin
            n_fail++;
            $display("FAIL b2b_access1: psel=%b en=%b wr=%b wdata=%h, expected 001 1 1 5e",
                     apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PWDATA);
        end
        @(negedge PCLK);
        transfer = 1'b0;
        n_checks++;
        if (xfer_done !== 1'b1 || apb.PSEL !== 3'b010 || apb.PENABLE !== 1'b0 || busy !== 1'b1 ||
            apb.PADDR !== 9'h090 || apb.PWRITE !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_setup2: done=%b psel=%b en=%b busy=%b addr=%h wr=%b, expected 1 010 0 1 090 0",
                     xfer_done, apb.PSEL, apb.PENABLE, busy, apb.PADDR, apb.PWRITE);
        end
        @(negedge PCLK);
        n_checks++;
        if (xfer_done !== 1'b0 || apb.PENABLE !== 1'b1 || apb.PSEL !== 3'b010) begin
            n_fail++;
            $display("FAIL b2b_access2: done=%b en=%b psel=%b, expected 0 1 010", xfer_done, apb.PENABLE, apb.PSEL);
        end
        @(negedge PCLK);
        n_checks++;
        if (xfer_done !== 1'b1 || apb.PSEL !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done2: done=%b psel=%b busy=%b, expected 1 000 0", xfer_done, apb.PSEL, busy);
        end
        @(negedge PCLK);
    endtask

    task automatic test_decode_error();
        drive_req(1'b1, 9'h180, 8'h00);
        push_exp(1'b1, 1'b1, '0);
        @(negedge PCLK);
        transfer = 1'b0;
        n_checks++;
        if (apb.PSEL !== '0 || apb.PENABLE !== 1'b0 || busy !== 1'b1 || xfer_done !== 1'b0) begin
            n_fail++;
            $display("FAIL decode_err_cycle: psel=%b en=%b busy=%b done=%b, expected 000 0 1 0",
                     apb.PSEL, apb.PENABLE, busy, xfer_done);
        end
        @(negedge PCLK);
        n_checks++;
        if (xfer_done !== 1'b1 || busy !== 1'b0 || apb.PSEL !== '0) begin
            n_fail++;
            $display("FAIL decode_err_done: done=%b busy=%b psel=%b, expected 1 0 000", xfer_done, busy, apb.PSEL);
        end
        @(negedge PCLK);
    endtask

    task automatic test_slave_error();
        int sel_cyc, en_cyc, unstable;
        bit done;
        logic [AW-1:0] addrs [3] = '{9'h000, 9'h100, 9'h020};
        logic [NS-1:0] sels  [3] = '{3'b001, 3'b100, 3'b001};
        bit            rds   [3] = '{1'b1, 1'b1, 1'b0};
        bit            errs  [3] = '{1'b1, 1'b0, 1'b1};
        logic [DW-1:0] rdat  [3] = '{8'hC3, 8'h5A, 8'h00};
        wait_cfg = 0;
        for (int k = 0; k < 3; k++) begin
            err_cfg = errs[k];
            drive_req(rds[k], addrs[k], 8'h77);
            push_exp(rds[k], errs[k], rdat[k]);
            @(negedge PCLK);
            transfer = 1'b0;
            run_to_done(sels[k], addrs[k], ~rds[k], sel_cyc, en_cyc, unstable, done);
            n_checks++;
            if (!done || en_cyc != 1 || unstable != 0) begin
                n_fail++;
                $display("FAIL slave_err_%0d: done=%b en_cycles=%0d unstable=%0d, expected 1 1 0",
                         k, done, en_cyc, unstable);
            end
            @(negedge PCLK);
        end
        err_cfg = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        int sel_cyc, en_cyc, unstable;
        bit done;
        n_checks++;
        if (PSLVERR !== 1'b1 || apb_read_data_out !== 8'h5A) begin
            n_fail++;
            $display("FAIL status_hold: PSLVERR=%b rdata=%h, expected 1 5a", PSLVERR, apb_read_data_out);
        end
        wait_cfg = -1;
        drive_req(1'b1, 9'h0A0, 8'h00);
        @(negedge PCLK);
        transfer = 1'b0;
        @(negedge PCLK);
        n_checks++;
        if (apb.PENABLE !== 1'b1 || apb.PSEL !== 3'b010) begin
            n_fail++;
            $display("FAIL pre_reset_access: en=%b psel=%b, expected 1 010", apb.PENABLE, apb.PSEL);
        end
        #2 PRESETn = 1'b0;
        #1;
        n_checks++;
        if ({apb.PSEL, apb.PENABLE, PSLVERR, apb_read_data_out, busy, xfer_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_access: psel=%b en=%b err=%b rdata=%h busy=%b done=%b, expected all 0",
                     apb.PSEL, apb.PENABLE, PSLVERR, apb_read_data_out, busy, xfer_done);
        end
        model_rdata = '0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (8) @(negedge PCLK);
        n_checks++;
        if (busy !== 1'b0 || apb.PSEL !== '0 || apb.PENABLE !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_abort: busy=%b psel=%b en=%b, expected 0 000 0", busy, apb.PSEL, apb.PENABLE);
        end
        wait_cfg = 0;
        drive_req(1'b1, 9'h000, 8'h00);
        push_exp(1'b1, 1'b0, 8'hC3);
        @(negedge PCLK);
        transfer = 1'b0;
        run_to_done(3'b001, 9'h000, 1'b0, sel_cyc, en_cyc, unstable, done);
        n_checks++;
        if (!done || sel_cyc != 2 || en_cyc != 1 || unstable != 0) begin
            n_fail++;
            $display("FAIL read_after_reset: done=%b sel_cycles=%0d en_cycles=%0d unstable=%0d, expected 1 2 1 0",
                     done, sel_cyc, en_cyc, unstable);
        end
        repeat (2) @(negedge PCLK);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_zero_wait_write();
        test_read_waits();
        test_timeout();
        test_back_to_back();
        test_decode_error();
        test_slave_error();
        test_reset_mid_access();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_completions: %0d left in queue, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
